// File: rtl/keypad_scan_matrix.sv
// -----------------------------------------------------------------------------
// keypad_scan_matrix
//
// Scans a ROWS x COLS keypad. The column lines are driven one at a time
// (active-low). The asynchronous active-low row lines are synchronised and
// sampled once per column. Whole scan frames are debounced before a key is
// accepted. Each accepted press produces a one-cycle key event carrying the
// linear key code (row*COLS + col). The block also reports key release and
// frames in which more than one key was pressed.
//
// Optional feature macro: KEYPAD_TYPEMATIC_EN
//   When defined, a held key re-pulses o_key_valid after REPEAT_DELAY frames,
//   then every REPEAT_RATE frames. When undefined, each press produces exactly
//   one key event, and the repeat counters are not built.
//
// Ports:
//   i_clk          scan clock; all logic runs on the rising edge
//   i_rst          synchronous reset, active-high
//   i_row_n        keypad rows; 0 = pressed on the driven column (asynchronous)
//   o_col_n        column drive; exactly one bit is 0 outside reset
//   o_key_code     last accepted key, row*COLS + col
//   o_key_valid    one-cycle pulse; o_key_code is newly valid
//   o_key_held     level; an accepted key is still down
//   o_key_release  one-cycle pulse when o_key_held falls
//   o_multi_key    level; the last completed frame had more than one key
// -----------------------------------------------------------------------------
module keypad_scan_matrix #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SETTLE       = 4,
    parameter int DEBOUNCE     = 4,
    parameter int RELEASE      = 8,
`ifdef KEYPAD_TYPEMATIC_EN
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8,
`endif
    parameter int CODE_W       = $clog2(ROWS*COLS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ROWS-1:0]   i_row_n,
    output logic [COLS-1:0]   o_col_n,
    output logic [CODE_W-1:0] o_key_code,
    output logic              o_key_valid,
    output logic              o_key_held,
    output logic              o_key_release,
    output logic              o_multi_key
);

    localparam int SET_W = $clog2(SETTLE);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int ST_W  = $clog2(DEBOUNCE + 1);
    localparam int EM_W  = $clog2(RELEASE + 1);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(DEBOUNCE);
    localparam logic [EM_W-1:0]  EM_MAX   = EM_W'(RELEASE);

`ifdef KEYPAD_TYPEMATIC_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
`endif

    // Row synchroniser
    logic [ROWS-1:0]   r_row_s1;
    logic [ROWS-1:0]   r_row_s2;

    // Scan sequencing: r_active stays low for the first cycle out of reset
    logic              r_active;
    logic [SET_W-1:0]  r_settle;
    logic [COL_W-1:0]  r_col;

    // Per-frame accumulation
    logic [1:0]        r_cnt;
    logic              r_cand_v;
    logic [CODE_W-1:0] r_cand;

    // Cross-frame debounce state
    logic              r_prev_v;
    logic [CODE_W-1:0] r_prev;
    logic [ST_W-1:0]   r_stable;
    logic [EM_W-1:0]   r_empty;

    // Registered outputs
    logic [COLS-1:0]   r_col_n;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;
    logic              r_key_held;
    logic              r_key_release;
    logic              r_multi_key;

`ifdef KEYPAD_TYPEMATIC_EN
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_rep_first;
    logic [REP_W-1:0]  w_rep_nx;
    logic [REP_W-1:0]  w_rep_target;
`endif

    logic [1:0]        w_col_cnt;
    logic              w_col_any;
    logic [ROW_W-1:0]  w_col_row;
    logic [CODE_W-1:0] w_col_code;
    logic [1:0]        w_base_cnt;
    logic              w_base_v;
    logic [2:0]        w_sum;
    logic [1:0]        w_frm_cnt;
    logic              w_frm_v;
    logic [CODE_W-1:0] w_frm_cand;
    logic              w_sample;
    logic              w_frame_end;
    logic [COL_W-1:0]  w_col_next;
    logic              w_same;
    logic [ST_W-1:0]   w_stable_nx;
    logic [EM_W-1:0]   w_empty_nx;
    logic              w_accept;

    // Decode the sampled column and merge it into the running frame summary
    always_comb begin
        w_col_cnt = 2'd0;
        w_col_any = 1'b0;
        w_col_row = '0;
        // Walk from the top row down so the lowest pressed row wins
        for (int r = ROWS - 1; r >= 0; r--) begin
            w_col_row = (!r_row_s2[r]) ? ROW_W'(r) : w_col_row;
            w_col_any = w_col_any | !r_row_s2[r];
            w_col_cnt = (!r_row_s2[r] && (w_col_cnt != 2'd2)) ? (w_col_cnt + 2'd1) : w_col_cnt;
        end
        w_col_code  = CODE_W'(int'(w_col_row) * COLS + int'(r_col));

        // Column 0 opens a new frame, so earlier accumulation is ignored
        w_base_cnt  = (r_col == '0) ? 2'd0 : r_cnt;
        w_base_v    = (r_col == '0) ? 1'b0 : r_cand_v;
        w_sum       = {1'b0, w_base_cnt} + {1'b0, w_col_cnt};
        w_frm_cnt   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_frm_v     = w_base_v | w_col_any;
        w_frm_cand  = w_base_v ? r_cand : w_col_code;

        w_sample    = r_active && (r_settle == SET_LAST);
        w_frame_end = w_sample && (r_col == COL_LAST);
        w_col_next  = (r_col == COL_LAST) ? '0 : (r_col + COL_W'(1));

        w_same      = r_prev_v && (w_frm_cand == r_prev);
        w_stable_nx = w_same ? ((r_stable == ST_MAX) ? ST_MAX : (r_stable + ST_W'(1))) : ST_W'(1);
        w_empty_nx  = (r_empty == EM_MAX) ? EM_MAX : (r_empty + EM_W'(1));
        // The same key already held does not generate a fresh event
        w_accept    = (w_stable_nx == ST_MAX) && ((w_frm_cand != r_key_code) || !r_key_held);
    end

`ifdef KEYPAD_TYPEMATIC_EN
    // Repeat counter next value and the interval currently being timed
    always_comb begin
        w_rep_nx     = r_rep_cnt + REP_W'(1);
        w_rep_target = r_rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
    end
`endif

    // Scan sequencing, row synchroniser, frame accumulation and key evaluation
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row_s1      <= '1;
            r_row_s2      <= '1;
            r_active      <= 1'b0;
            r_settle      <= '0;
            r_col         <= '0;
            r_cnt         <= 2'd0;
            r_cand_v      <= 1'b0;
            r_cand        <= '0;
            r_prev_v      <= 1'b0;
            r_prev        <= '0;
            r_stable      <= '0;
            r_empty       <= '0;
            r_col_n       <= '1;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_held    <= 1'b0;
            r_key_release <= 1'b0;
            r_multi_key   <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            r_rep_cnt     <= '0;
            r_rep_first   <= 1'b1;
`endif
        end else begin
            r_row_s1      <= i_row_n;
            r_row_s2      <= r_row_s1;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            if (!r_active) begin
                // First cycle out of reset: start driving column 0
                r_active <= 1'b1;
                r_col_n  <= ~COLS'(1);
            end else if (w_sample) begin
                r_settle <= '0;
                r_col    <= w_col_next;
                r_col_n  <= ~(COLS'(1) << w_col_next);
                r_cnt    <= w_frm_cnt;
                r_cand_v <= w_frm_v;
                r_cand   <= w_frm_cand;
                if (w_frame_end) begin
                    r_prev_v    <= w_frm_v;
                    r_prev      <= w_frm_cand;
                    r_multi_key <= (w_frm_cnt == 2'd2);
                    case (w_frm_cnt)
                        2'd0: begin
                            r_empty  <= w_empty_nx;
                            r_stable <= '0;
                            if (r_key_held && (w_empty_nx == EM_MAX)) begin
                                r_key_held    <= 1'b0;
                                r_key_release <= 1'b1;
                            end
`ifdef KEYPAD_TYPEMATIC_EN
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b1;
`endif
                        end
                        2'd1: begin
                            r_empty  <= '0;
                            r_stable <= w_stable_nx;
                            if (w_accept) begin
                                r_key_code  <= w_frm_cand;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                            end
`ifdef KEYPAD_TYPEMATIC_EN
                            if (w_accept) begin
                                r_rep_cnt   <= '0;
                                r_rep_first <= 1'b1;
                            end else if (r_key_held && (w_stable_nx == ST_MAX) && (w_frm_cand == r_key_code)) begin
                                if (w_rep_nx == w_rep_target) begin
                                    r_key_valid <= 1'b1;
                                    r_rep_cnt   <= '0;
                                    r_rep_first <= 1'b0;
                                end else begin
                                    r_rep_cnt   <= w_rep_nx;
                                end
                            end else begin
                                r_rep_cnt   <= '0;
                                r_rep_first <= 1'b1;
                            end
`endif
                        end
                        default: begin
                            r_stable <= '0;
                            r_empty  <= '0;
`ifdef KEYPAD_TYPEMATIC_EN
                            r_rep_cnt   <= '0;
                            r_rep_first <= 1'b1;
`endif
                        end
                    endcase
                end
            end else begin
                r_settle <= r_settle + SET_W'(1);
            end
        end
    end

    assign o_col_n       = r_col_n;
    assign o_key_code    = r_key_code;
    assign o_key_valid   = r_key_valid;
    assign o_key_held    = r_key_held;
    assign o_key_release = r_key_release;
    assign o_multi_key   = r_multi_key;

endmodule

// File: tb/tb_keypad_scan_matrix.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_matrix
//
// The bench emulates a keypad matrix that responds to the driven column. It
// applies directed and random key patterns one whole scan frame at a time.
// A frame-level reference model predicts the key events, which are queued.
// A monitor pops and compares an entry whenever the DUT pulses an event.
// -----------------------------------------------------------------------------
module tb_keypad_scan_matrix;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SETTLE   = 4;
    localparam int DEBOUNCE = 4;
    localparam int RELEASE  = 8;
    localparam int CODE_W   = 4;
    localparam int NKEYS    = ROWS * COLS;
    localparam int FRAME    = COLS * SETTLE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ROWS-1:0]   row_n;
    logic [COLS-1:0]   col_n;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;
    logic              key_release;
    logic              multi_key;

    logic [NKEYS-1:0]  pressed = '0;

    typedef struct {
        bit is_rel;
        int code;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model state
    int m_held  = 0;
    int m_code  = 0;
    int m_multi = 0;
    int m_last  = -1;
    int m_run   = 0;
    int m_empty = 0;

    keypad_scan_matrix #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SETTLE   (SETTLE),
        .DEBOUNCE (DEBOUNCE),
        .RELEASE  (RELEASE)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_row_n       (row_n),
        .o_col_n       (col_n),
        .o_key_code    (key_code),
        .o_key_valid   (key_valid),
        .o_key_held    (key_held),
        .o_key_release (key_release),
        .o_multi_key   (multi_key)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_n = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!col_n[c] && pressed[r*COLS + c]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every event pulse is compared with the oldest prediction
    always @(negedge clk) begin
        if (!rst && (key_valid || key_release)) begin
            check("valid_release_exclusive", int'(key_valid & key_release), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_is_release", int'(key_release), int'(mon_e.is_rel));
                check("event_held", int'(key_held), mon_e.is_rel ? 0 : 1);
                if (!mon_e.is_rel) check("event_code", int'(key_code), mon_e.code);
            end
        end
    end

    task automatic model_reset();
        m_held  = 0;
        m_code  = 0;
        m_multi = 0;
        m_last  = -1;
        m_run   = 0;
        m_empty = 0;
    endtask

    // Reference model: the frame's key set in, predicted events queued out
    task automatic model_frame(input logic [NKEYS-1:0] m);
        int cnt;
        int k;
        cnt = $countones(m);
        k   = -1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (k < 0 && m[r*COLS + c]) k = r*COLS + c;
        m_multi = (cnt >= 2) ? 1 : 0;
        if (cnt == 0) begin
            m_empty++;
            m_run  = 0;
            m_last = -1;
            if (m_held != 0 && m_empty == RELEASE) begin
                m_held = 0;
                exp_q.push_back('{1'b1, 0});
            end
        end else if (cnt == 1) begin
            m_empty = 0;
            m_run   = (k == m_last) ? m_run + 1 : 1;
            m_last  = k;
            if (m_run >= DEBOUNCE && (k != m_code || m_held == 0)) begin
                m_held = 1;
                m_code = k;
                exp_q.push_back('{1'b0, k});
            end
        end else begin
            m_empty = 0;
            m_run   = 0;
            m_last  = -1;
        end
    endtask

    // Called one time unit after a frame starts; returns likewise at the next start
    task automatic run_frame(input logic [NKEYS-1:0] m, input bit chk_cols);
        logic [COLS-1:0] exp_col;
        pressed = m;
        model_frame(m);
        for (int i = 0; i < FRAME; i++) begin
            if (chk_cols) begin
                exp_col = ~(COLS'(1) << (i / SETTLE));
                check("col_scan", int'(col_n), int'(exp_col));
            end
            @(posedge clk);
            #1;
        end
        exp_col = ~COLS'(1);
        check("frame_start_col", int'(col_n), int'(exp_col));
        check("key_held", int'(key_held), m_held);
        check("multi_key", int'(multi_key), m_multi);
        check("key_code", int'(key_code), m_code);
    endtask

    task automatic run_frames(input logic [NKEYS-1:0] m, input int n);
        for (int i = 0; i < n; i++) run_frame(m, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        logic [COLS-1:0] exp_col;
        int n;
        check("queue_drained_before_reset", exp_q.size(), 0);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_col_n", int'(col_n), int'({COLS{1'b1}}));
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_held", int'(key_held), 0);
        check("rst_key_release", int'(key_release), 0);
        check("rst_multi_key", int'(multi_key), 0);
        model_reset();
        rst = 1'b0;
        exp_col = ~COLS'(1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (col_n != exp_col && n < 20);
        check("first_col_after_reset", int'(col_n), int'(exp_col));
        check("first_col_latency", n, 1);
    endtask

    function automatic logic [NKEYS-1:0] key(input int k);
        logic [NKEYS-1:0] m;
        m    = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NKEYS-1:0] m;
        int sel;
        int len;
        int k1;
        int k2;
        int rk;

        // Reset release and an idle keypad
        do_reset(4);
        run_frame('0, 1'b1);
        run_frames('0, 19);

        // Clean press of key 6 (row 1, col 2), then a long hold
        run_frames(key(6), 4);
        run_frames(key(6), 10);

        // Release after eight empty frames
        run_frames('0, 8);

        // Bouncing contact on alternate frames, then a steady press
        for (int i = 0; i < 12; i++) run_frame((i % 2 == 0) ? key(6) : '0, 1'b0);
        run_frames(key(6), 4);

        // Seven-frame gap is short of release; re-pressing key 6 gives no event
        run_frames('0, 7);
        run_frames(key(6), 4);
        run_frames('0, 8);

        // Keys 0 and 5 together, then key 5 lifted
        run_frames(key(0) | key(5), 6);
        run_frames(key(0), 4);
        run_frames('0, 8);

        // Rollover from key 6 to key 9 without release
        run_frames(key(6), 4);
        run_frames(key(9), 4);

        // Reset during the third debounce frame of key 3
        run_frames(key(3), 2);
        pressed = key(3);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        do_reset(3);
        run_frames(key(3), 4);
        run_frames('0, 8);

        // Random bursts of empty, single, bouncing and multi-key frames
        rk = $urandom_range(0, NKEYS-1);
        for (int b = 0; b < 60; b++) begin
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 12);
            if (sel < 3) begin
                m = '0;
            end else if (sel < 8) begin
                if (sel >= 6) rk = $urandom_range(0, NKEYS-1);
                m = key(rk);
            end else begin
                k1 = $urandom_range(0, NKEYS-1);
                k2 = (k1 + $urandom_range(1, NKEYS-1)) % NKEYS;
                m  = key(k1) | key(k2);
            end
            for (int i = 0; i < len; i++)
                run_frame(($urandom_range(0, 9) == 0) ? '0 : m, 1'b0);
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
